m10k_write_buffer: RTL

Upstream stage that fills the M10K block whose rows the read buffer later fetches. On start it snapshots a COL-row matrix and writes it one row per cycle to consecutive M10K addresses beginning at OFFSET. It then waits one settle cycle and holds DONE until released. The OFFSET/COL layout matches the read buffer, so a completed write is immediately readable.

---
 rtl/m10k_write_buffer_pkg.sv | 13 +
 rtl/m10k_write_buffer.sv | 71 +++++++
 2 files changed

// File: rtl/m10k_write_buffer_pkg.sv
// m10k_write_buffer_pkg: state codes shared with the read buffer, row and counter sizing helpers.
package m10k_write_buffer_pkg;
  localparam logic [3:0] IDLE  = 4'd15;
  localparam logic [3:0] WRITE = 4'd1;
  localparam logic [3:0] WAIT  = 4'd13;
  localparam logic [3:0] DONE  = 4'd14;
  function automatic int row_size(input int data_len, input int k);
    return data_len * k;
  endfunction
  function automatic int cnt_w(input int col);
    return col > 1 ? $clog2(col) : 1;
  endfunction
endpackage

// File: rtl/m10k_write_buffer.sv
// m10k_write_buffer: snapshots a COL-row matrix and writes it row by row into M10K from OFFSET.
// Optional M10K_WRITE_ZERO_SKIP_EN suppresses the write enable for all-zero rows.
module m10k_write_buffer
  import m10k_write_buffer_pkg::*;
#(
  parameter int DATA_LEN     = 32,
  parameter int K            = 8,
  parameter int COL          = 12,
  parameter int ADDRESS_SIZE = 4,
  parameter int OFFSET       = 4,
  parameter int ROW_SIZE     = row_size(DATA_LEN, K)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_write_start,
  input  logic                    i_write_reset,
  input  logic [ROW_SIZE*COL-1:0] i_store_mat,
  output logic [ADDRESS_SIZE-1:0] o_write_addr,
  output logic [ROW_SIZE-1:0]     o_write_data,
  output logic                    o_write_en,
  output logic [3:0]              o_state,
  output logic                    o_done
);
  localparam int CNT_W = cnt_w(COL);
  if (OFFSET + COL - 1 > 2**ADDRESS_SIZE - 1) begin : g_bad_layout
    $error("m10k_write_buffer: OFFSET+COL-1 exceeds the M10K address range");
  end
  logic [3:0]              state;
  logic [CNT_W-1:0]        row_cnt;
  logic [ROW_SIZE*COL-1:0] shadow;
  logic                    in_wr;
  logic                    last_row;
  logic [CNT_W-1:0]        sel;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      row_cnt <= '0;
      shadow  <= '0;
    end else begin
      case (state)
        IDLE: if (i_write_start) begin
          state   <= WRITE;
          row_cnt <= '0;
          shadow  <= i_store_mat;
        end
        WRITE: begin
          state   <= last_row ? WAIT : WRITE;
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end
        WAIT:    state <= DONE;
        DONE:    state <= i_write_reset ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
  // Outputs stay combinational: the M10K registers its own write port.
  always_comb begin
    in_wr        = state == WRITE;
    last_row     = row_cnt == CNT_W'(COL - 1);
    sel          = in_wr ? row_cnt : '0;
    o_write_data = shadow[ROW_SIZE*int'(sel) +: ROW_SIZE];
    o_write_addr = ADDRESS_SIZE'(OFFSET) + ADDRESS_SIZE'(sel);
`ifdef M10K_WRITE_ZERO_SKIP_EN
    o_write_en   = in_wr && |o_write_data;
`else
    o_write_en   = in_wr;
`endif
    o_state      = state;
    o_done       = state == DONE;
  end
endmodule
